// File: rtl/i_buf_enable_sequencer.sv
// Staggered power-up/power-down sequencer for a bank of input buffers, with a synchroniser on their outputs.
// Optional per-bit glitch filter on DATA is built when I_BUF_SEQ_GLITCH_FILTER_EN is defined.
module i_buf_enable_sequencer #(
    parameter int NUM_BUF        = 4,
    parameter int STAGGER_CYCLES = 3,
    parameter int SETTLE_CYCLES  = 5,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic               STOP,
    input  logic [NUM_BUF-1:0] BUF_O,
    output logic [NUM_BUF-1:0] EN,
    output logic [NUM_BUF-1:0] DATA,
    output logic               READY,
    output logic               BUSY
);

    localparam int MAX_SS  = (STAGGER_CYCLES > SETTLE_CYCLES) ? STAGGER_CYCLES : SETTLE_CYCLES;
    localparam int CNT_MAX = (MAX_SS > FILTER_CYCLES) ? MAX_SS : FILTER_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] STAGGER_RELOAD = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_RELOAD  = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    if (NUM_BUF < 1 || NUM_BUF > 32) begin : g_bad_num_buf
        $fatal(1, "%m: NUM_BUF=%0d must be in 1..32", NUM_BUF);
    end
    if (STAGGER_CYCLES < 1) begin : g_bad_stagger
        $fatal(1, "%m: STAGGER_CYCLES=%0d must be >= 1", STAGGER_CYCLES);
    end
    if (SETTLE_CYCLES < 0) begin : g_bad_settle
        $fatal(1, "%m: SETTLE_CYCLES=%0d must be >= 0", SETTLE_CYCLES);
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "%m: SYNC_STAGES=%0d must be >= 2", SYNC_STAGES);
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $fatal(1, "%m: FILTER_CYCLES=%0d must be >= 1", FILTER_CYCLES);
    end

    typedef enum logic [2:0] {S_IDLE, S_RAMP_UP, S_SETTLE, S_ACTIVE, S_RAMP_DOWN} state_t;

    state_t             state_q, state_d;
    logic [NUM_BUF-1:0] en_q, en_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_BUF-1:0] en_up;
    logic [NUM_BUF-1:0] data_src;

    // EN is always a thermometer code, so shifting adds the next-lowest or drops the highest set bit
    assign en_up = (en_q << 1) | NUM_BUF'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            en_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (START && !STOP) begin
                    en_d  = en_up;
                    cnt_d = STAGGER_RELOAD;
                    if (en_up[NUM_BUF-1]) begin
                        state_d = (SETTLE_CYCLES == 0) ? S_ACTIVE : S_SETTLE;
                        cnt_d   = SETTLE_RELOAD;
                    end else begin
                        state_d = S_RAMP_UP;
                    end
                end
            end
            S_RAMP_UP: begin
                if (STOP) begin
                    state_d = S_RAMP_DOWN;
                    en_d    = en_q >> 1;
                    cnt_d   = STAGGER_RELOAD;
                end else if (cnt_q == '0) begin
                    en_d  = en_up;
                    cnt_d = STAGGER_RELOAD;
                    if (en_up[NUM_BUF-1]) begin
                        state_d = (SETTLE_CYCLES == 0) ? S_ACTIVE : S_SETTLE;
                        cnt_d   = SETTLE_RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (STOP) begin
                    state_d = S_RAMP_DOWN;
                    en_d    = en_q >> 1;
                    cnt_d   = STAGGER_RELOAD;
                end else if (cnt_q == '0) begin
                    state_d = S_ACTIVE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACTIVE: begin
                if (STOP) begin
                    state_d = S_RAMP_DOWN;
                    en_d    = en_q >> 1;
                    cnt_d   = STAGGER_RELOAD;
                end
            end
            S_RAMP_DOWN: begin
                if (en_q == '0) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    en_d  = en_q >> 1;
                    cnt_d = STAGGER_RELOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                en_d    = '0;
                cnt_d   = '0;
            end
        endcase
    end

    logic [NUM_BUF-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= BUF_O;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

`ifdef I_BUF_SEQ_GLITCH_FILTER_EN
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [NUM_BUF-1:0] filt_q;
    logic [CNT_W-1:0]   fcnt_q [NUM_BUF];

    // A bit follows the synchroniser only once it has disagreed with it for FILTER_CYCLES cycles in a row
    always_ff @(posedge CLK) begin
        if (RST || !READY) begin
            filt_q <= '0;
            for (int b = 0; b < NUM_BUF; b++) fcnt_q[b] <= '0;
        end else begin
            for (int b = 0; b < NUM_BUF; b++) begin
                if (sync_q[SYNC_STAGES-1][b] != filt_q[b]) begin
                    if (fcnt_q[b] == FILT_LAST) begin
                        filt_q[b] <= sync_q[SYNC_STAGES-1][b];
                        fcnt_q[b] <= '0;
                    end else begin
                        fcnt_q[b] <= fcnt_q[b] + CNT_W'(1);
                    end
                end else begin
                    fcnt_q[b] <= '0;
                end
            end
        end
    end

    assign data_src = filt_q;
`else
    assign data_src = sync_q[SYNC_STAGES-1];
`endif

    always_comb begin
        READY = (state_q == S_ACTIVE);
        BUSY  = (state_q != S_IDLE);
        EN    = en_q;
        DATA  = data_src & {NUM_BUF{READY}};
    end

endmodule

// File: tb/tb_i_buf_enable_sequencer.sv
// Scoreboard bench for i_buf_enable_sequencer: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_i_buf_enable_sequencer;

    localparam int K_EN   = 0;
    localparam int K_RDY  = 1;
    localparam int K_BUSY = 2;
    localparam int K_DATA = 3;
`ifdef I_BUF_SEQ_GLITCH_FILTER_EN
    localparam int FL = 4;
`else
    localparam int FL = 0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       STOP = 1'b0;
    logic [3:0] BUF_O = 4'b1111;
    logic [3:0] EN;
    logic [3:0] DATA;
    logic       READY;
    logic       BUSY;

    i_buf_enable_sequencer #(
        .NUM_BUF(4), .STAGGER_CYCLES(3), .SETTLE_CYCLES(5), .SYNC_STAGES(2), .FILTER_CYCLES(4)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .BUF_O(BUF_O),
        .EN(EN), .DATA(DATA), .READY(READY), .BUSY(BUSY)
    );

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic exp_at(input int c, input int kind, input logic [31:0] v, input string name);
        exp_t e;
        e.cyc = c; e.kind = kind; e.val = v; e.name = name;
        sb.push_back(e);
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge CLK);
            #1;
        end
    endtask

    always @(negedge CLK) begin : monitor
        logic [31:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                case (sb[i].kind)
                    K_EN:    act = 32'(EN);
                    K_RDY:   act = 32'(READY);
                    K_BUSY:  act = 32'(BUSY);
                    default: act = 32'(DATA);
                endcase
                checks++;
                if (act !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s @cyc %0d: got %0h expected %0h", sb[i].name, cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, with all buffer outputs high
        exp_at(3, K_EN, 0, "rst_en");
        exp_at(3, K_RDY, 0, "rst_ready");
        exp_at(3, K_BUSY, 0, "rst_busy");
        exp_at(3, K_DATA, 0, "rst_data");
        goto(4); RST = 1'b0;

        // Ramp-up; DATA stays masked until READY
        goto(10); START = 1'b1;
        exp_at(11, K_EN, 4'b0001, "up_en11");
        exp_at(11, K_BUSY, 1, "up_busy11");
        exp_at(13, K_EN, 4'b0001, "up_en13");
        exp_at(14, K_EN, 4'b0011, "up_en14");
        exp_at(16, K_EN, 4'b0011, "up_en16");
        exp_at(17, K_EN, 4'b0111, "up_en17");
        exp_at(19, K_EN, 4'b0111, "up_en19");
        exp_at(20, K_EN, 4'b1111, "up_en20");
        exp_at(20, K_RDY, 0, "up_rdy20");
        exp_at(24, K_RDY, 0, "up_rdy24");
        exp_at(24, K_DATA, 0, "data_masked24");
        exp_at(25, K_RDY, 1, "up_rdy25");
        exp_at(25, K_EN, 4'b1111, "up_en25");
        exp_at(25 + FL, K_DATA, 4'b1111, "data_all_ones");
        goto(11); START = 1'b0;

        // Data latency while ACTIVE
        goto(30); BUF_O = 4'b1010;
        exp_at(31 + FL, K_DATA, 4'b1111, "data_old");
        exp_at(32 + FL, K_DATA, 4'b1010, "data_new");

        // START ignored while ACTIVE
        goto(35); START = 1'b1;
        exp_at(36, K_EN, 4'b1111, "active_start_en");
        exp_at(36, K_RDY, 1, "active_start_rdy");
        goto(36); START = 1'b0;

        // Ramp-down from ACTIVE
        goto(40); STOP = 1'b1;
        exp_at(40, K_RDY, 1, "dn_rdy40");
        exp_at(41, K_RDY, 0, "dn_rdy41");
        exp_at(41, K_EN, 4'b0111, "dn_en41");
        exp_at(41, K_DATA, 0, "dn_data41");
        exp_at(41, K_BUSY, 1, "dn_busy41");
        exp_at(43, K_EN, 4'b0111, "dn_en43");
        exp_at(44, K_EN, 4'b0011, "dn_en44");
        exp_at(47, K_EN, 4'b0001, "dn_en47");
        exp_at(49, K_EN, 4'b0001, "dn_en49");
        exp_at(50, K_EN, 4'b0000, "dn_en50");
        exp_at(50, K_BUSY, 1, "dn_busy50");
        exp_at(51, K_BUSY, 0, "dn_busy51");
        goto(41); STOP = 1'b0;

        // START and STOP together in IDLE
        goto(55); START = 1'b1; STOP = 1'b1;
        exp_at(56, K_EN, 0, "both_en56");
        exp_at(56, K_BUSY, 0, "both_busy56");
        exp_at(60, K_BUSY, 0, "both_busy60");
        goto(56); START = 1'b0; STOP = 1'b0;

        // Abort mid ramp-up; START during RAMP_DOWN ignored
        goto(70); START = 1'b1;
        exp_at(71, K_EN, 4'b0001, "ab_en71");
        exp_at(74, K_EN, 4'b0011, "ab_en74");
        goto(71); START = 1'b0;
        goto(75); STOP = 1'b1;
        exp_at(76, K_EN, 4'b0001, "ab_en76");
        exp_at(76, K_RDY, 0, "ab_rdy76");
        exp_at(78, K_EN, 4'b0001, "ab_en78");
        exp_at(79, K_EN, 4'b0000, "ab_en79");
        exp_at(79, K_BUSY, 1, "ab_busy79");
        exp_at(80, K_BUSY, 0, "ab_busy80");
        exp_at(81, K_EN, 4'b0000, "ab_en81");
        goto(76); STOP = 1'b0;
        goto(77); START = 1'b1;
        goto(78); START = 1'b0;

        // Reset mid-ramp, then a full replay
        goto(90); START = 1'b1;
        exp_at(91, K_EN, 4'b0001, "rr_en91");
        exp_at(94, K_EN, 4'b0011, "rr_en94");
        exp_at(97, K_EN, 4'b0111, "rr_en97");
        goto(91); START = 1'b0;
        goto(98); RST = 1'b1;
        exp_at(99, K_EN, 0, "rr_rst_en");
        exp_at(99, K_RDY, 0, "rr_rst_rdy");
        exp_at(99, K_BUSY, 0, "rr_rst_busy");
        exp_at(101, K_EN, 0, "rr_idle_en");
        goto(99); RST = 1'b0;
        goto(110); START = 1'b1;
        exp_at(111, K_EN, 4'b0001, "rp_en111");
        exp_at(111, K_BUSY, 1, "rp_busy111");
        exp_at(113, K_EN, 4'b0001, "rp_en113");
        exp_at(114, K_EN, 4'b0011, "rp_en114");
        exp_at(117, K_EN, 4'b0111, "rp_en117");
        exp_at(120, K_EN, 4'b1111, "rp_en120");
        exp_at(124, K_RDY, 0, "rp_rdy124");
        exp_at(125, K_RDY, 1, "rp_rdy125");
        goto(111); START = 1'b0;
        goto(130); STOP = 1'b1;
        exp_at(131, K_EN, 4'b0111, "rp_dn131");
        exp_at(141, K_BUSY, 0, "rp_busy141");
        goto(131); STOP = 1'b0;

        // STOP during SETTLE
        goto(145); START = 1'b1;
        exp_at(155, K_EN, 4'b1111, "st_en155");
        exp_at(157, K_RDY, 0, "st_rdy157");
        goto(146); START = 1'b0;
        goto(157); STOP = 1'b1;
        exp_at(158, K_EN, 4'b0111, "st_en158");
        exp_at(158, K_RDY, 0, "st_rdy158");
        exp_at(161, K_EN, 4'b0011, "st_en161");
        exp_at(164, K_EN, 4'b0001, "st_en164");
        exp_at(167, K_EN, 4'b0000, "st_en167");
        exp_at(168, K_BUSY, 0, "st_busy168");
        goto(158); STOP = 1'b0;

        // Short and long pulses on BUF_O[1] while ACTIVE
        goto(175); START = 1'b1; BUF_O = 4'b0000;
        exp_at(190, K_RDY, 1, "pl_rdy190");
        exp_at(190, K_DATA, 0, "pl_data190");
        goto(176); START = 1'b0;
        goto(200); BUF_O = 4'b0010;
        exp_at(203, K_DATA, (FL != 0) ? 32'h0 : 32'h2, "short_pulse203");
        exp_at(206, K_DATA, 0, "short_pulse206");
        goto(202); BUF_O = 4'b0000;
        goto(210); BUF_O = 4'b0010;
        exp_at(211 + FL, K_DATA, 0, "long_pulse_pre");
        exp_at(212 + FL, K_DATA, 4'b0010, "long_pulse_rise");
        exp_at(217 + FL, K_DATA, 4'b0010, "long_pulse_hold");
        exp_at(218 + FL, K_DATA, 0, "long_pulse_fall");
        goto(216); BUF_O = 4'b0000;

        goto(230);
        checks++;
        if (EN !== 4'b1111) begin
            errors++;
            $display("FAIL final_en @cyc %0d: got %0h expected f", cyc, EN);
        end
        checks++;
        if (READY !== 1'b1) begin
            errors++;
            $display("FAIL final_ready @cyc %0d: got %0h expected 1", cyc, READY);
        end
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL final_busy @cyc %0d: got %0h expected 1", cyc, BUSY);
        end
        checks++;
        if (DATA !== 4'b0000) begin
            errors++;
            $display("FAIL final_data @cyc %0d: got %0h expected 0", cyc, DATA);
        end
        while (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s: expectation for cyc %0d never compared", sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
